// File: rtl/nibble_serial_subtractor.sv
// Serial subtractor: computes a - b one 4-bit look-ahead slice per clock,
// chaining the slice carry through a register, with valid/ready on both sides.
module nibble_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             zero
);

  localparam int NSLICE = WIDTH / 4;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] nb_p0;
  logic [IDX_W-1:0] idx;
  logic             carry;

  logic [WIDTH-1:0] a_sh, nb_sh, slice_sh, mask_sh, diff_nxt;
  logic [3:0]       sum_sl;
  logic             cout_sl;
  logic             last;
  logic             ovf_nxt;

  // 4-bit carry-look-ahead add; returns {carry_out, sum}.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic cin);
    logic [3:0] p, g;
    logic [4:0] c;
    p    = x ^ y;
    g    = x & y;
    c[0] = cin;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    return {c[4], p ^ c[3:0]};
  endfunction

  // Slice datapath: select nibble idx, add with registered carry, merge into diff
  always_comb begin
    a_sh              = a_p0 >> {idx, 2'b00};
    nb_sh             = nb_p0 >> {idx, 2'b00};
    {cout_sl, sum_sl} = cla4(a_sh[3:0], nb_sh[3:0], carry);
    slice_sh          = WIDTH'(sum_sl) << {idx, 2'b00};
    mask_sh           = WIDTH'(4'hF) << {idx, 2'b00};
    diff_nxt          = (diff & ~mask_sh) | slice_sh;
    last              = (idx == IDX_W'(NSLICE - 1));
    // a and ~b share a sign bit exactly when a and b differ in sign
    ovf_nxt           = (a_p0[WIDTH-1] == nb_p0[WIDTH-1]) &&
                        (diff_nxt[WIDTH-1] != a_p0[WIDTH-1]);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = CALC;
      CALC:    if (last)     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      idx       <= '0;
      carry     <= 1'b0;
      diff      <= '0;
      borrow    <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (in_valid) begin
            idx   <= '0;
            carry <= 1'b1;
          end
        end
        CALC: begin
          diff  <= diff_nxt;
          carry <= cout_sl;
          idx   <= idx + IDX_W'(1);
          if (last) begin
            borrow <= ~cout_sl;
            ovf    <= ovf_nxt;
            zero   <= (diff_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

  // Operand capture (stage 0): subtrahend is stored inverted for a + ~b + 1
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      a_p0  <= a;
      nb_p0 <= ~b;
    end
  end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Self-checking bench for nibble_serial_subtractor (WIDTH = 16) against a
// plain-arithmetic reference of a - b and its flags.
module tb_nibble_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        in_ready, out_valid, borrow, ovf, zero;
  logic [15:0] diff;

  int passed = 0;
  int total  = 0;

  nibble_serial_subtractor #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow(borrow), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  // Reference: {borrow, ovf, zero, diff}
  function automatic logic [18:0] ref_sub(input logic [15:0] x, input logic [15:0] y);
    logic [16:0] w;
    logic [15:0] d;
    logic        br, ov, z;
    w  = {1'b0, x} - {1'b0, y};
    d  = w[15:0];
    br = w[16];
    ov = (x[15] != y[15]) && (d[15] != x[15]);
    z  = (d == 16'd0);
    return {br, ov, z, d};
  endfunction

  // Drives one operation with out_ready held high and reports what came back.
  task automatic run_op(input logic [15:0] x, input logic [15:0] y,
                        output logic [18:0] got, output int lat, output logic ir_after);
    @(negedge clk);
    a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    got = {borrow, ovf, zero, diff};
    @(posedge clk); #1;
    ir_after = in_ready && !out_valid;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
    total++; if ({borrow, ovf, zero, diff} !== 19'd0)
      $display("FAIL reset_outputs: got %h want 0", {borrow, ovf, zero, diff}); else passed++;
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b want 1", in_ready); else passed++;
  endtask

  task automatic test_directed;
    logic [15:0] va [5] = '{16'h1234, 16'h1000, 16'h0000, 16'h8000, 16'h5A5A};
    logic [15:0] vb [5] = '{16'h0234, 16'h0001, 16'h0001, 16'h0001, 16'h5A5A};
    logic [18:0] got, exp;
    int          lat;
    logic        ir;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], got, lat, ir);
      exp = ref_sub(va[i], vb[i]);
      total++; if (lat !== 4) $display("FAIL dir%0d_latency: got %0d want 4", i, lat); else passed++;
      total++; if (got[15:0] !== exp[15:0]) $display("FAIL dir%0d_diff: got %h want %h", i, got[15:0], exp[15:0]); else passed++;
      total++; if (got[18] !== exp[18]) $display("FAIL dir%0d_borrow: got %b want %b", i, got[18], exp[18]); else passed++;
      total++; if (got[17] !== exp[17]) $display("FAIL dir%0d_ovf: got %b want %b", i, got[17], exp[17]); else passed++;
      total++; if (got[16] !== exp[16]) $display("FAIL dir%0d_zero: got %b want %b", i, got[16], exp[16]); else passed++;
      total++; if (ir !== 1'b1) $display("FAIL dir%0d_ready_after: got %b want 1", i, ir); else passed++;
    end
  endtask

  task automatic test_backpressure;
    logic [18:0] held, exp;
    int          cnt;
    @(negedge clk);
    a = 16'hBEEF; b = 16'h1234; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    held = {borrow, ovf, zero, diff};
    exp  = ref_sub(16'hBEEF, 16'h1234);
    total++; if (held !== exp) $display("FAIL bp_result: got %h want %h", held, exp); else passed++;
    for (int k = 0; k < 3; k++) begin
      a = 16'($urandom); b = 16'($urandom); in_valid = ~in_valid;
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
        $display("FAIL bp_hold%0d_handshake: got valid=%b ready=%b want 1/0", k, out_valid, in_ready); else passed++;
      total++; if ({borrow, ovf, zero, diff} !== held)
        $display("FAIL bp_hold%0d_stable: got %h want %h", k, {borrow, ovf, zero, diff}, held); else passed++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL bp_release: got valid=%b ready=%b want 0/1", out_valid, in_ready); else passed++;
  endtask

  task automatic test_reset_mid;
    logic [18:0] got;
    int          lat;
    logic        ir;
    logic        seen;
    @(negedge clk);
    a = 16'h7777; b = 16'h1111; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL rstmid_handshake: got valid=%b ready=%b want 0/1", out_valid, in_ready); else passed++;
    total++; if ({borrow, ovf, zero, diff} !== 19'd0)
      $display("FAIL rstmid_outputs: got %h want 0", {borrow, ovf, zero, diff}); else passed++;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) $display("FAIL rstmid_no_stale_result: got %b want 0", seen); else passed++;
    run_op(16'h0003, 16'h0005, got, lat, ir);
    total++; if (got[15:0] !== 16'hFFFE) $display("FAIL rstmid_next_diff: got %h want fffe", got[15:0]); else passed++;
    total++; if (got[18] !== 1'b1) $display("FAIL rstmid_next_borrow: got %b want 1", got[18]); else passed++;
  endtask

  task automatic test_back_to_back;
    localparam int N = 1000;
    logic [18:0] expq[$];
    logic [18:0] e;
    int          sent, recv, cyc;
    logic        fire_in, fire_out;
    sent = 0; recv = 0; cyc = 0;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    while (recv < N && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      if (fire_out) begin
        if (expq.size() == 0) begin
          total++;
          $display("FAIL b2b_unexpected_result: got %h want none", {borrow, ovf, zero, diff});
        end else begin
          e = expq.pop_front();
          total++; if (diff !== e[15:0]) $display("FAIL b2b%0d_diff: got %h want %h", recv, diff, e[15:0]); else passed++;
          total++; if (borrow !== e[18]) $display("FAIL b2b%0d_borrow: got %b want %b", recv, borrow, e[18]); else passed++;
          total++; if (ovf !== e[17]) $display("FAIL b2b%0d_ovf: got %b want %b", recv, ovf, e[17]); else passed++;
          total++; if (zero !== e[16]) $display("FAIL b2b%0d_zero: got %b want %b", recv, zero, e[16]); else passed++;
        end
        recv++;
      end
      if (fire_in) begin
        expq.push_back(ref_sub(a, b));
        sent++;
      end
      @(posedge clk); #1;
      if (fire_in || !in_valid) begin
        if (sent < N && $urandom_range(0, 3) != 0) begin
          in_valid = 1'b1;
          a = 16'($urandom);
          b = 16'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 2) != 0);
    end
    in_valid = 1'b0;
    total++; if (recv !== N) $display("FAIL b2b_received: got %0d want %0d", recv, N); else passed++;
    total++; if (sent !== N) $display("FAIL b2b_sent: got %0d want %0d", sent, N); else passed++;
    total++; if (expq.size() !== 0) $display("FAIL b2b_leftover: got %0d want 0", expq.size()); else passed++;
  endtask

  initial begin
    test_reset;
    test_directed;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
